// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends a raw immediate per mode (sign/zero/upper/branch)
// at input acceptance and buffers result+tag in a 2-entry FIFO with registered in_ready.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  immediate,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic [1:0]       dbg_state
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t             state, state_next;
  logic             in_ready_q;
  logic             wr_ptr, rd_ptr;
  logic [OUT_W-1:0] res_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic [OUT_W-1:0] sign_val, ext_val;
  logic             in_fire, out_fire;

  // Handshake: a side transfers on a rising edge where its valid and ready are both 1;
  // an input transfer additionally requires flush=0. Ready never depends on valid.
  assign in_fire  = in_valid && in_ready_q && !flush;
  assign out_fire = out_valid && out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != OCC_EMPTY);
  assign result    = res_mem[rd_ptr];
  assign tag_out   = tag_mem[rd_ptr];
  assign dbg_state = state;

  always_comb begin
    sign_val = {{EXT_W{immediate[IN_W-1]}}, immediate};
    ext_val  = sign_val;
    case (mode)
      2'b00:   ext_val = sign_val;
      2'b01:   ext_val = {{EXT_W{1'b0}}, immediate};
      2'b10:   ext_val = {immediate, {EXT_W{1'b0}}};
      default: ext_val = {sign_val[OUT_W-3:0], 2'b00};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      OCC_EMPTY: if (in_fire) state_next = OCC_ONE;
      OCC_ONE: begin
        if (in_fire && !out_fire)      state_next = OCC_FULL;
        else if (!in_fire && out_fire) state_next = OCC_EMPTY;
      end
      OCC_FULL:  if (out_fire) state_next = OCC_ONE;
      default:   state_next = OCC_EMPTY;
    endcase
    if (flush) state_next = OCC_EMPTY;
  end

  // in_ready is registered from the next occupancy, so it stays 0 throughout reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != OCC_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      res_mem[0] <= '0;
      res_mem[1] <= '0;
      tag_mem[0] <= '0;
      tag_mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (in_fire) begin
        res_mem[wr_ptr] <= ext_val;
        tag_mem[wr_ptr] <= tag_in;
        wr_ptr          <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed testbench for imm_extend_unit: default-parameter instance plus a 12->16 bit instance.
module tb_imm_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [15:0] immediate;
  logic [1:0]  mode;
  logic [4:0]  tag_in, tag_out;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_flush;
  logic [11:0] p_immediate;
  logic [1:0]  p_mode;
  logic [4:0]  p_tag_in, p_tag_out;
  logic [15:0] p_result;
  logic [1:0]  p_dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [36:0] exp_q[$];
  logic [36:0] got;

  localparam logic [15:0] MV_IMM [6] = '{16'h00FF, 16'h80FF, 16'h80FF, 16'h1234, 16'hFFFF, 16'h0004};
  localparam logic [1:0]  MV_MODE[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  localparam logic [31:0] MV_EXP [6] = '{32'h000000FF, 32'hFFFF80FF, 32'h000080FF,
                                         32'h12340000, 32'hFFFFFFFC, 32'h00000010};

  imm_extend_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .immediate(immediate), .mode(mode), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .dbg_state(dbg_state)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(16), .TAG_W(5)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .immediate(p_immediate), .mode(p_mode), .tag_in(p_tag_in), .flush(p_flush),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .result(p_result),
    .tag_out(p_tag_out), .dbg_state(p_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] imm, input logic [1:0] m, input logic [4:0] t);
    in_valid  = 1'b1;
    immediate = imm;
    mode      = m;
    tag_in    = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    total_cnt++; if (tag_out !== 5'h0) $display("FAIL reset_tag: got %h want 0", tag_out); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL release_before_edge: got %b want 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_modes();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer(MV_IMM[i], MV_MODE[i], 5'(i + 1));
      tick();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL mode%0d_valid: got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (result !== MV_EXP[i]) $display("FAIL mode%0d_result: got %h want %h", i, result, MV_EXP[i]); else pass_cnt++;
      total_cnt++; if (tag_out !== 5'(i + 1)) $display("FAIL mode%0d_tag: got %0d want %0d", i, tag_out, i + 1); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mode%0d_one_cycle: got %b want 0", i, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(16'h8001, 2'b00, 5'd1);
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (tag_out !== 5'd1) $display("FAIL bp_tag_first: got %0d want 1", tag_out); else pass_cnt++;
    offer(16'h8002, 2'b01, 5'd2);
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else pass_cnt++;
    offer(16'h0003, 2'b10, 5'd3);
    repeat (2) tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFF8001) $display("FAIL bp_stable_result: got %h want ffff8001", result); else pass_cnt++;
    total_cnt++; if (tag_out !== 5'd1) $display("FAIL bp_stable_tag: got %0d want 1", tag_out); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (result !== 32'h00008002) $display("FAIL bp_second_result: got %h want 00008002", result); else pass_cnt++;
    total_cnt++; if (tag_out !== 5'd2) $display("FAIL bp_second_tag: got %0d want 2", tag_out); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_reopen: got %b want 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (result !== 32'h00030000) $display("FAIL bp_third_result: got %h want 00030000", result); else pass_cnt++;
    total_cnt++; if (tag_out !== 5'd3) $display("FAIL bp_third_tag: got %0d want 3", tag_out); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_streaming();
    int bubbles;
    int ready_drops;
    bubbles     = 0;
    ready_drops = 0;
    out_ready   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(16'h0100 + 16'(i), 2'b01, 5'(i));
      tick();
      exp_q.push_back({5'(i), 32'h00000100 + 32'(i)});
      if (in_ready !== 1'b1) ready_drops++;
      if (out_valid !== 1'b1) bubbles++;
      else begin
        got = exp_q.pop_front();
        total_cnt++;
        if ({tag_out, result} !== got)
          $display("FAIL stream_item%0d: got %h/%h want %h/%h", i, tag_out, result, got[36:32], got[31:0]);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    tick();
    total_cnt++; if (bubbles != 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles); else pass_cnt++;
    total_cnt++; if (ready_drops != 0) $display("FAIL stream_ready: got %0d drops want 0", ready_drops); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_end_valid: got %b want 0", out_valid); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    int leaked;
    leaked    = 0;
    out_ready = 1'b0;
    offer(16'h0007, 2'b00, 5'd7);
    tick();
    offer(16'h0008, 2'b00, 5'd8);
    tick();
    total_cnt++; if (dbg_state !== 2'd2) $display("FAIL flush_full_state: got %0d want 2", dbg_state); else pass_cnt++;
    offer(16'h0009, 2'b00, 5'd9);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_full_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_full_ready: got %b want 1", in_ready); else pass_cnt++;
    // flush from ONE while an input is acceptable: the input must be dropped
    offer(16'h000A, 2'b00, 5'd10);
    tick();
    offer(16'h000B, 2'b00, 5'd11);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_one_valid: got %b want 0", out_valid); else pass_cnt++;
    repeat (3) begin
      tick();
      if (out_valid !== 1'b0) leaked++;
    end
    total_cnt++; if (leaked != 0) $display("FAIL flush_leak: got %0d cycles valid want 0", leaked); else pass_cnt++;
    offer(16'h000C, 2'b00, 5'd12);
    tick();
    in_valid = 1'b0;
    total_cnt++; if (tag_out !== 5'd12 || result !== 32'h0000000C)
      $display("FAIL flush_after_item: got %0d/%h want 12/0000000c", tag_out, result); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    offer(16'h0055, 2'b00, 5'd20);
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", out_valid); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({out_valid, in_ready} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {out_valid, in_ready}); else pass_cnt++;
    total_cnt++; if (result !== 32'h0 || tag_out !== 5'h0)
      $display("FAIL rst_mid_data: got %h/%h want 0/0", result, tag_out); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    offer(16'h0015, 2'b00, 5'd21);
    tick();
    in_valid = 1'b0;
    total_cnt++; if (tag_out !== 5'd21 || result !== 32'h00000015)
      $display("FAIL rst_mid_first_out: got %0d/%h want 21/00000015", tag_out, result); else pass_cnt++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_param_sweep();
    p_out_ready = 1'b1;
    p_in_valid  = 1'b1;
    p_immediate = 12'h800;
    p_mode      = 2'b00;
    p_tag_in    = 5'd4;
    tick();
    total_cnt++; if (p_out_valid !== 1'b1 || p_result !== 16'hF800)
      $display("FAIL param_sign: got %b/%h want 1/f800", p_out_valid, p_result); else pass_cnt++;
    p_immediate = 12'h7FF;
    p_mode      = 2'b11;
    p_tag_in    = 5'd5;
    tick();
    p_in_valid = 1'b0;
    total_cnt++; if (p_result !== 16'h1FFC || p_tag_out !== 5'd5)
      $display("FAIL param_branch: got %h/%0d want 1ffc/5", p_result, p_tag_out); else pass_cnt++;
    tick();
  endtask

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    immediate   = '0;
    mode        = '0;
    tag_in      = '0;
    p_in_valid  = 1'b0;
    p_out_ready = 1'b0;
    p_flush     = 1'b0;
    p_immediate = '0;
    p_mode      = '0;
    p_tag_in    = '0;
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reset_midstream();
    test_param_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 16: immediate field width in bits.
REQ-002 Parameter OUT_W, default 32: extended result width in bits; legal range IN_W+2 <= OUT_W <= 64.
REQ-003 Parameter TAG_W, default 5: width of the side-band tag carried with each result, e.g. destination register number.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  immediate, mode and tag are presented this cycle.
REQ-007 in_ready  out  1  unit can accept an item this cycle.
REQ-008 immediate  in  IN_W  raw immediate field, MSB is the sign bit.
REQ-009 mode  in  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
REQ-010 tag_in  in  TAG_W  side-band tag.
REQ-011 flush  in  1  synchronous discard of all buffered items.
REQ-012 out_valid  out  1  result and tag_out are valid.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 result  out  OUT_W  extended value.
REQ-015 tag_out  out  TAG_W  tag paired with result.

Function
REQ-016 An input transfer occurs on a rising edge where in_valid=1, in_ready=1 and flush=0; an output transfer occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-017 SIGN mode: result = immediate with its MSB replicated into bits OUT_W-1..IN_W.
REQ-018 ZERO mode: result = immediate with bits OUT_W-1..IN_W cleared.
REQ-019 UPPER mode: result = immediate placed in bits OUT_W-1..OUT_W-IN_W, with all lower bits zero.
REQ-020 BRANCH mode: result = SIGN-mode value shifted left 2; the two LSBs are zero and the shifted-out bits are dropped.
REQ-021 Extension is computed at the input transfer; the result and tag are stored in a 2-entry FIFO.
REQ-022 Latency: an item accepted at edge N into an empty FIFO appears on result/out_valid after edge N, visible in cycle N+1; there is no combinational path from input to output.
REQ-023 FIFO occupancy states: EMPTY (0), ONE (1), FULL (2); out_valid=1 in ONE and FULL.
REQ-024 in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL.
REQ-025 in_ready is a registered function of the occupancy state only and does not depend combinationally on out_ready.
REQ-026 Input and output transfer on the same edge: occupancy is unchanged, and a ONE-state item is replaced in order.
REQ-027 Output transfer alone: occupancy decreases by 1.
REQ-028 Input transfer alone: occupancy increases by 1.
REQ-029 Items leave in strict acceptance order, and each tag_out always matches its own result.
REQ-030 While out_valid=1 and out_ready=0, result and tag_out shall hold stable.
REQ-031 flush=1 at an edge: occupancy becomes EMPTY and out_valid=0 from the next cycle; any input offered at that edge is dropped; flush takes priority over simultaneous input and output transfers.
REQ-032 The FIFO read and write pointers wrap modulo 2 with no lost or duplicated entries.
REQ-033 A mode value is used only at its own input transfer, so a mode change between items has no effect on buffered results.

Reset
REQ-034 While rst_n=0, occupancy shall be EMPTY, out_valid=0, in_ready=0, result=0 and tag_out=0, asynchronously.
REQ-035 in_ready shall rise on the first rising edge after rst_n deasserts.
REQ-036 Assertion of reset mid-operation discards all buffered items, and no partial item appears after release.

Verification
REQ-037 Extension per mode, defaults, out_ready=1:
  - SIGN 0x00FF -> 0x000000FF; SIGN 0x80FF -> 0xFFFF80FF.
  - ZERO 0x80FF -> 0x000080FF.
  - UPPER 0x1234 -> 0x12340000.
  - BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x0004 -> 0x00000010.
  - Each result valid exactly 1 cycle after acceptance.
REQ-038 Backpressure: out_ready=0, offer tags 1, 2 and 3 on consecutive cycles -> in_ready drops after the second acceptance and tag 3 is held by the source; raise out_ready -> tags 1, 2, 3 emerge in order with values stable while stalled.
REQ-039 Streaming: in_valid=1 and out_ready=1 for 20 cycles with incrementing immediates -> 20 results in order with no bubbles after the first, and in_ready remains 1.
REQ-040 Flush: FIFO FULL, assert flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed items and the offered item never appear.
REQ-041 Reset mid-stream: pull rst_n low with the FIFO at ONE -> all outputs are 0 immediately; after release the first accepted item is the first output.
REQ-042 Parameter sweep: IN_W=12, OUT_W=16, SIGN 0x800 -> 0xF800, and BRANCH 0x7FF -> 0x1FFC.
